// File: rtl/nabp_line_buffer.sv
// Ping-pong projection-line buffer between the NABP filler and the mapper/shifter.
// One bank fills sequentially while the other is read at random addresses.
module nabp_line_buffer #(
  parameter int unsigned P_LINE_SIZE = 256,
  parameter int unsigned S_WIDTH     = 9,
  parameter int unsigned DATA_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         fl_valid,
  input  logic        [DATA_WIDTH-1:0] fl_data,
  output logic                         fl_ready,
  input  logic                         sh_kick,
  input  logic                         sh_shift_enable,
  input  logic                         sh_done,
  input  logic signed [S_WIDTH-1:0]    rm_s_val,
  output logic                         lb_line_ready,
  output logic        [DATA_WIDTH-1:0] rm_data,
  output logic                         rm_data_valid,
  output logic        [1:0]            lb_lines
);

  localparam int unsigned AW = (P_LINE_SIZE > 1) ? $clog2(P_LINE_SIZE) : 1;

  localparam logic [0:0] IdleS    = 1'b0;
  localparam logic [0:0] MappingS = 1'b1;

  logic [1:0]            full_q, full_d;
  logic                  wb_q, wb_d;
  logic                  rb_q, rb_d;
  logic [AW-1:0]         wptr_q, wptr_d;
  logic [0:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] rm_data_q, rm_data_d;
  logic                  rm_data_valid_q, rm_data_valid_d;

  logic [DATA_WIDTH-1:0] mem_q [2][P_LINE_SIZE];

  logic          fill_acc;
  logic          fill_last;
  logic          release_bank;
  logic          rd_en;
  logic          rd_in_range;
  logic [AW-1:0] rd_addr;
  int            s_int;

  assign fl_ready      = reset_n && !full_q[wb_q];
  assign fill_acc      = fl_valid && fl_ready;
  assign fill_last     = fill_acc && (wptr_q == AW'(P_LINE_SIZE - 1));
  assign release_bank  = (state_q == MappingS) && sh_done;
  assign rd_en         = (state_q == MappingS) && sh_shift_enable;

  // Sign-extend so negative addresses fall outside the line instead of wrapping.
  assign s_int       = int'(rm_s_val);
  assign rd_in_range = (s_int >= 0) && (s_int < int'(P_LINE_SIZE));
  assign rd_addr     = AW'(s_int);

  assign lb_line_ready = (state_q == IdleS) && full_q[rb_q];
  assign lb_lines      = {1'b0, full_q[0]} + {1'b0, full_q[1]};
  assign rm_data       = rm_data_q;
  assign rm_data_valid = rm_data_valid_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IdleS: begin
        if (sh_kick && full_q[rb_q]) begin
          state_d = MappingS;
        end
      end
      MappingS: begin
        if (sh_done) begin
          state_d = IdleS;
        end
      end
      default: state_d = IdleS;
    endcase
  end

  // Fill and release never address the same bank: one needs it empty, the other full.
  always_comb begin
    full_d = full_q;
    wb_d   = wb_q;
    rb_d   = rb_q;
    wptr_d = wptr_q;
    if (fill_acc) begin
      wptr_d = fill_last ? '0 : wptr_q + 1'b1;
    end
    if (fill_last) begin
      full_d[wb_q] = 1'b1;
      wb_d         = ~wb_q;
    end
    if (release_bank) begin
      full_d[rb_q] = 1'b0;
      rb_d         = ~rb_q;
    end
  end

  always_comb begin
    rm_data_d       = rm_data_q;
    rm_data_valid_d = rd_en;
    if (rd_en) begin
      rm_data_d = rd_in_range ? mem_q[rb_q][rd_addr] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      full_q          <= '0;
      wb_q            <= 1'b0;
      rb_q            <= 1'b0;
      wptr_q          <= '0;
      state_q         <= IdleS;
      rm_data_q       <= '0;
      rm_data_valid_q <= 1'b0;
    end else begin
      full_q          <= full_d;
      wb_q            <= wb_d;
      rb_q            <= rb_d;
      wptr_q          <= wptr_d;
      state_q         <= state_d;
      rm_data_q       <= rm_data_d;
      rm_data_valid_q <= rm_data_valid_d;
    end
  end

  // Storage needs no reset; the full flags decide what is valid.
  always_ff @(posedge clk) begin
    if (fill_acc) begin
      mem_q[wb_q][wptr_q] <= fl_data;
    end
  end

endmodule

// File: tb/tb_nabp_line_buffer.sv
// Self-checking bench for nabp_line_buffer: read results go through a scoreboard queue,
// read address/expected pairs come from a vector table, corner cases are hand-sequenced.
module tb_nabp_line_buffer;

  localparam int unsigned PL = 8;
  localparam int unsigned SW = 5;
  localparam int unsigned DW = 16;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 fl_valid = 1'b0;
  logic        [DW-1:0] fl_data = '0;
  logic                 fl_ready;
  logic                 sh_kick = 1'b0;
  logic                 sh_shift_enable = 1'b0;
  logic                 sh_done = 1'b0;
  logic signed [SW-1:0] rm_s_val = '0;
  logic                 lb_line_ready;
  logic        [DW-1:0] rm_data;
  logic                 rm_data_valid;
  logic        [1:0]    lb_lines;

  int n_pass  = 0;
  int n_total = 0;
  logic [DW-1:0] sb[$];

  typedef struct {
    logic signed [SW-1:0] s;
    logic [DW-1:0]        exp;
  } rd_vec_t;

  rd_vec_t vecs[7];

  nabp_line_buffer #(
    .P_LINE_SIZE(PL),
    .S_WIDTH    (SW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .fl_valid       (fl_valid),
    .fl_data        (fl_data),
    .fl_ready       (fl_ready),
    .sh_kick        (sh_kick),
    .sh_shift_enable(sh_shift_enable),
    .sh_done        (sh_done),
    .rm_s_val       (rm_s_val),
    .lb_line_ready  (lb_line_ready),
    .rm_data        (rm_data),
    .rm_data_valid  (rm_data_valid),
    .lb_lines       (lb_lines)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (rm_data_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL rd_unexpected: got valid data 0x%0h, expected no read result", rm_data);
      end else begin
        logic [DW-1:0] e;
        e = sb.pop_front();
        chk("rd_data", 32'(rm_data), 32'(e));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [DW-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      int guard = 0;
      fl_valid = 1'b1;
      fl_data  = base + DW'(i);
      while (!fl_ready && guard < 20) begin
        tick();
        guard++;
      end
      if (!fl_ready) chk("fill_timeout", 32'(fl_ready), 32'd1);
      tick();
    end
    fl_valid = 1'b0;
  endtask

  task automatic rd(input logic signed [SW-1:0] s, input logic [DW-1:0] exp);
    sh_shift_enable = 1'b1;
    rm_s_val        = s;
    sb.push_back(exp);
    tick();
    sh_shift_enable = 1'b0;
  endtask

  task automatic drain();
    tick();
    chk("sb_drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic kick();
    sh_kick = 1'b1;
    tick();
    sh_kick = 1'b0;
  endtask

  task automatic done();
    sh_done = 1'b1;
    tick();
    sh_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{s: 5'sd0,  exp: 16'h0010};
    vecs[1] = '{s: 5'sd3,  exp: 16'h0013};
    vecs[2] = '{s: 5'sd7,  exp: 16'h0017};
    vecs[3] = '{s: -5'sd1, exp: 16'h0000};
    vecs[4] = '{s: 5'sd8,  exp: 16'h0000};
    vecs[5] = '{s: 5'sd7,  exp: 16'h0017};
    vecs[6] = '{s: 5'sd5,  exp: 16'h0015};

    // Reset state
    tick();
    tick();
    chk("rst_fl_ready", 32'(fl_ready), 32'd0);
    chk("rst_lb_lines", 32'(lb_lines), 32'd0);
    chk("rst_rm_valid", 32'(rm_data_valid), 32'd0);
    chk("rst_rm_data", 32'(rm_data), 32'd0);
    chk("rst_line_ready", 32'(lb_line_ready), 32'd0);
    reset_n = 1'b1;
    tick();
    chk("post_rst_fl_ready", 32'(fl_ready), 32'd1);

    // 1 + 3: basic fill and table-driven reads, including out-of-range addresses
    fill(16'h0010, PL);
    chk("t1_lines", 32'(lb_lines), 32'd1);
    chk("t1_line_ready", 32'(lb_line_ready), 32'd1);
    kick();
    chk("t1_map_line_ready", 32'(lb_line_ready), 32'd0);
    foreach (vecs[i]) begin
      sh_shift_enable = 1'b1;
      rm_s_val        = vecs[i].s;
      sb.push_back(vecs[i].exp);
      tick();
    end
    sh_shift_enable = 1'b0;
    drain();
    done();
    chk("t1_lines_done", 32'(lb_lines), 32'd0);
    chk("t1_line_ready_done", 32'(lb_line_ready), 32'd0);

    // 2: both banks full stalls the filler
    fill(16'h0010, PL);
    fill(16'h0020, PL);
    chk("t2_lines", 32'(lb_lines), 32'd2);
    fl_valid = 1'b1;
    fl_data  = 16'h0040;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_stall_ready", 32'(fl_ready), 32'd0);
    end
    fl_valid = 1'b0;
    chk("t2_lines_stall", 32'(lb_lines), 32'd2);
    kick();
    rd(5'sd1, 16'h0011);
    drain();
    done();
    chk("t2_release_ready", 32'(fl_ready), 32'd1);
    chk("t2_lines_rel", 32'(lb_lines), 32'd1);
    chk("t2_line_ready_b", 32'(lb_line_ready), 32'd1);
    kick();
    rd(5'sd2, 16'h0022);
    rd(5'sd0, 16'h0020);
    rd(5'sd7, 16'h0027);
    drain();

    // 5: line completes on the same edge as sh_done of the other bank
    fill(16'h0050, PL - 1);
    fl_valid = 1'b1;
    fl_data  = 16'h0057;
    sh_done  = 1'b1;
    chk("t5_pre_line_ready", 32'(lb_line_ready), 32'd0);
    tick();
    fl_valid = 1'b0;
    sh_done  = 1'b0;
    chk("t5_lines", 32'(lb_lines), 32'd1);
    chk("t5_line_ready", 32'(lb_line_ready), 32'd1);
    kick();
    rd(5'sd4, 16'h0054);
    drain();
    done();
    chk("t5_lines_done", 32'(lb_lines), 32'd0);

    // 4: kick with no full bank is ignored; read+done on the same cycle
    kick();
    chk("t4_idle_line_ready", 32'(lb_line_ready), 32'd0);
    sh_shift_enable = 1'b1;
    rm_s_val        = 5'sd2;
    tick();
    sh_shift_enable = 1'b0;
    chk("t4_idle_valid", 32'(rm_data_valid), 32'd0);
    chk("t4_idle_hold", 32'(rm_data), 32'h0054);
    fill(16'h0010, PL);
    kick();
    sh_shift_enable = 1'b1;
    sh_done         = 1'b1;
    rm_s_val        = 5'sd2;
    sb.push_back(16'h0012);
    tick();
    sh_done  = 1'b0;
    rm_s_val = 5'sd3;
    chk("t4_lines", 32'(lb_lines), 32'd0);
    chk("t4_line_ready", 32'(lb_line_ready), 32'd0);
    tick();
    sh_shift_enable = 1'b0;
    chk("t4_post_valid", 32'(rm_data_valid), 32'd0);
    chk("t4_drain", 32'(sb.size()), 32'd0);

    // 6: reset mid-fill and mid-mapping discards everything
    fill(16'h0070, PL);
    kick();
    fill(16'h0060, 5);
    rd(5'sd2, 16'h0072);
    drain();
    reset_n = 1'b0;
    tick();
    chk("t6_rst_fl_ready", 32'(fl_ready), 32'd0);
    chk("t6_rst_lines", 32'(lb_lines), 32'd0);
    chk("t6_rst_data", 32'(rm_data), 32'd0);
    chk("t6_rst_valid", 32'(rm_data_valid), 32'd0);
    chk("t6_rst_line_ready", 32'(lb_line_ready), 32'd0);
    reset_n = 1'b1;
    tick();
    fill(16'h0030, PL);
    chk("t6_lines", 32'(lb_lines), 32'd1);
    kick();
    rd(5'sd0, 16'h0030);
    rd(5'sd6, 16'h0036);
    drain();
    done();
    chk("t6_lines_done", 32'(lb_lines), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
